core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Arbitrates the core's two memory ports (instruction fetch, data load/store) onto a single main-memory request/response channel. Sits directly below the pipelined core. Drives the core's `icache_*`/`dcache_*` handshake signals (`req_ready`, `resp_valid`, `dout`). Holds one pending request per port and keeps at most one memory transaction outstanding.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data width. Fixed at 32 for the 4-bit byte mask.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `icache_addr` in ADDR_W: fetch address.
- `icache_re` in 1: fetch request.
- `icache_req_ready` out 1: fetch slot free.
- `icache_resp_valid` out 1: one-cycle pulse, `icache_dout` updated.
- `icache_dout` out DATA_W: last fetched word, held.
- `dcache_addr` in ADDR_W: data address.
- `dcache_re` in 1: load request.
- `dcache_we` in 4: store byte mask.
- `dcache_din` in DATA_W: store data.
- `dcache_req_ready` out 1: data slot free.
- `dcache_resp_valid` out 1: one-cycle pulse on load completion.
- `dcache_dout` out DATA_W: last load word, held.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_rw` out 1: 1 = write.
- `mem_req_addr` out ADDR_W: memory address.
- `mem_req_data` out DATA_W: write data.
- `mem_req_mask` out 4: write byte mask.
- `mem_resp_valid` in 1: read data valid.
- `mem_resp_data` in DATA_W: read data.

## Operation
- Each port has a one-entry slot. `*_req_ready` = !slot_valid, driven straight from a flop.
- I-slot capture: on `icache_re && icache_req_ready`, latch the address.
- D-slot capture: on `(dcache_re || |dcache_we) && dcache_req_ready`, latch address, data and mask.
  - Nonzero `dcache_we` makes the request a write, whatever `dcache_re` is.
- FSM states:
  - IDLE: when a slot is valid, go to ISSUE, registering the grant and driving the `mem_req_*` fields.
  - ISSUE: `mem_req_valid`=1. On `mem_req_ready`:
    - write: free the D-slot, return to IDLE. Writes produce no `dcache_resp_valid`.
    - read: go to WAIT.
  - WAIT: on `mem_resp_valid`:
    - register data into the granted port's `dout`;
    - pulse that port's `resp_valid` next cycle;
    - free the slot in the same cycle as the pulse;
    - return to IDLE.
- Arbitration when both slots are valid in IDLE: grant the port opposite `last_grant` (round-robin). When only one slot is valid, grant it. `last_grant` updates on every grant.
- `mem_req_*` fields stay stable while `mem_req_valid` is high and not yet accepted.
- `mem_resp_valid` outside WAIT is ignored and discarded.
- `*_dout` changes only on that port's response.

## Timing
- Reset values:
  - `icache_req_ready`=1, `dcache_req_ready`=1
  - `icache_resp_valid`=0, `dcache_resp_valid`=0
  - `mem_req_valid`=0, `mem_req_rw`=0
  - `mem_req_addr`, `mem_req_data`, `mem_req_mask`, `icache_dout`, `dcache_dout` = 0
  - state IDLE, `last_grant`=icache (so dcache wins the first tie)
- Read, idle arbiter: request accepted at cycle N, `mem_req_valid` at N+2, response at M, `resp_valid` at M+1.
  - Minimum latency is 4 cycles with a 1-cycle memory.
- Write: slot frees the cycle after `mem_req_ready`. `dcache_req_ready` rises that cycle.
- `req_ready` is low from N+1 until the cycle of `resp_valid`. A new request can be accepted in the `resp_valid` cycle.
- Requests arriving in both ports in the same cycle are both captured and served one after the other.
- Reset asserted mid-transaction:
  - clears all slots and the FSM immediately;
  - the in-flight memory response is discarded (IDLE);
  - no `resp_valid` is issued for it.

## Structure
- Package `core_mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT);
  - grant encoding GNT_I=0, GNT_D=1;
  - byte-mask width constant 4.
- Sub-module `mem_req_slot`: one-entry valid/addr/data/mask/rw holding register with capture/free controls, instantiated twice. The I-slot ties its data, mask and rw inputs to 0.
- The FSM, arbiter and response routing live in the top level.

## Test plan
- Single fetch to 0x100, memory returns 0xDEADBEEF one cycle after accept: `icache_resp_valid` pulses exactly once, `icache_dout`=0xDEADBEEF, `icache_req_ready` low N+1..resp cycle.
- Store of 0x12345678, mask 4'b0011, to 0x200: `mem_req_rw`=1, data and mask unchanged, no `dcache_resp_valid`, `dcache_req_ready` back high the cycle after `mem_req_ready`.
- Fetch and load issued in the same cycle with `last_grant` at reset: load served first, then fetch. Repeat with both slots continuously refilled: grants strictly alternate D, I, D, I.
- `mem_req_ready` held low for 5 cycles in ISSUE: `mem_req_addr`, `mem_req_data`, `mem_req_rw` and `mem_req_mask` all stable, `mem_req_valid` stays high.
- Reset pulsed during WAIT, followed by a late `mem_resp_valid` with 0xCAFEF00D: no `resp_valid` pulse, `dout`=0, both `req_ready`=1.
- `dcache_re`=1 with `dcache_we`=4'b1111: treated as a write, no response pulse.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arb_pkg
// Purpose  : Shared types and constants for the core memory arbiter:
//            FSM state encoding, grant encoding and byte-mask width.
// Revision : 1.0 - initial release
// ============================================================================
package core_mem_arb_pkg;

    localparam int c_MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter_if
// Purpose  : Bundles the instruction-fetch port, the data load/store port and
//            the main-memory request/response channel of the arbiter.
//            master : arbiter view (serves the core, masters memory)
//            slave  : environment view (core ports plus memory model)
// Revision : 1.0 - initial release
// ============================================================================
interface core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import core_mem_arb_pkg::*;

    // Instruction fetch port
    logic [ADDR_W-1:0]   icache_addr;
    logic                icache_re;
    logic                icache_req_ready;
    logic                icache_resp_valid;
    logic [DATA_W-1:0]   icache_dout;

    // Data load/store port
    logic [ADDR_W-1:0]   dcache_addr;
    logic                dcache_re;
    logic [c_MASK_W-1:0] dcache_we;
    logic [DATA_W-1:0]   dcache_din;
    logic                dcache_req_ready;
    logic                dcache_resp_valid;
    logic [DATA_W-1:0]   dcache_dout;

    // Main memory channel
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_rw;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_data;
    logic [c_MASK_W-1:0] mem_req_mask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;

    modport master (
        input  icache_addr, icache_re,
        output icache_req_ready, icache_resp_valid, icache_dout,
        input  dcache_addr, dcache_re, dcache_we, dcache_din,
        output dcache_req_ready, dcache_resp_valid, dcache_dout,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output icache_addr, icache_re,
        input  icache_req_ready, icache_resp_valid, icache_dout,
        output dcache_addr, dcache_re, dcache_we, dcache_din,
        input  dcache_req_ready, dcache_resp_valid, dcache_dout,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/core_mem_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_slot
// Purpose  : One-entry request holding register (valid/addr/data/mask/rw).
//            Ports: i_capture loads the entry, i_free empties it; o_* expose
//            the held request. Capture wins if both are asserted, although
//            the arbiter never frees an empty slot nor captures into a full one.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_slot
    import core_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_capture,
    input  wire logic                i_free,
    input  wire logic [ADDR_W-1:0]   i_addr,
    input  wire logic [DATA_W-1:0]   i_data,
    input  wire logic [c_MASK_W-1:0] i_mask,
    input  wire logic                i_rw,
    output logic                     o_valid,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [DATA_W-1:0]        o_data,
    output logic [c_MASK_W-1:0]      o_mask,
    output logic                     o_rw
);

    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [c_MASK_W-1:0] r_mask;
    logic                r_rw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_rw    <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_mask  <= i_mask;
            r_rw    <= i_rw;
        end else if (i_free) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_mask  = r_mask;
    assign o_rw    = r_rw;

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Arbitrates the instruction-fetch and data ports onto a single
//            main-memory channel with one outstanding transaction.
//            clk   : rising-edge clock
//            reset : asynchronous, active-low
//            bus   : core_mem_arbiter_if.master (fetch port, data port,
//                    memory request/response channel)
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    core_mem_arbiter_if.master bus
);

    logic                w_i_valid, w_d_valid;
    logic [ADDR_W-1:0]   w_i_addr, w_d_addr;
    logic [DATA_W-1:0]   w_i_data, w_d_data;
    logic [c_MASK_W-1:0] w_i_mask, w_d_mask;
    logic                w_i_rw, w_d_rw;
    logic                w_i_capture, w_d_capture;
    logic                w_i_free, w_d_free;
    logic                w_d_is_write;
    grant_t              w_next_grant;

    state_t              r_state;
    grant_t              r_last_grant;   // also identifies the port being served
    logic                r_req_valid;
    logic                r_req_rw;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_data;
    logic [c_MASK_W-1:0] r_req_mask;
    logic                r_i_resp_valid, r_d_resp_valid;
    logic [DATA_W-1:0]   r_i_dout, r_d_dout;

    // Any nonzero byte mask makes the request a store, even with dcache_re set.
    assign w_d_is_write = |bus.dcache_we;
    assign w_i_capture  = bus.icache_re && !w_i_valid;
    assign w_d_capture  = (bus.dcache_re || w_d_is_write) && !w_d_valid;

    // Reads free their slot with the response; stores free on memory accept.
    assign w_i_free = (r_state == WAIT) && bus.mem_resp_valid && (r_last_grant == GNT_I);
    assign w_d_free = ((r_state == WAIT) && bus.mem_resp_valid && (r_last_grant == GNT_D))
                   || ((r_state == ISSUE) && bus.mem_req_ready && r_req_rw);

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_slot (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_i_capture),
        .i_free    (w_i_free),
        .i_addr    (bus.icache_addr),
        .i_data    ('0),
        .i_mask    ('0),
        .i_rw      (1'b0),
        .o_valid   (w_i_valid),
        .o_addr    (w_i_addr),
        .o_data    (w_i_data),
        .o_mask    (w_i_mask),
        .o_rw      (w_i_rw)
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_slot (
        .clk       (clk),
        .reset     (reset),
        .i_capture (w_d_capture),
        .i_free    (w_d_free),
        .i_addr    (bus.dcache_addr),
        .i_data    (bus.dcache_din),
        .i_mask    (bus.dcache_we),
        .i_rw      (w_d_is_write),
        .o_valid   (w_d_valid),
        .o_addr    (w_d_addr),
        .o_data    (w_d_data),
        .o_mask    (w_d_mask),
        .o_rw      (w_d_rw)
    );

    // Round-robin on a tie; a lone valid slot always wins.
    always_comb begin
        w_next_grant = GNT_I;
        if (w_i_valid && w_d_valid) begin
            w_next_grant = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (w_d_valid) begin
            w_next_grant = GNT_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_last_grant   <= GNT_I;
            r_req_valid    <= 1'b0;
            r_req_rw       <= 1'b0;
            r_req_addr     <= '0;
            r_req_data     <= '0;
            r_req_mask     <= '0;
            r_i_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            r_i_dout       <= '0;
            r_d_dout       <= '0;
        end else begin
            r_i_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_i_valid || w_d_valid) begin
                        r_last_grant <= w_next_grant;
                        r_req_valid  <= 1'b1;
                        r_state      <= ISSUE;
                        if (w_next_grant == GNT_D) begin
                            r_req_rw   <= w_d_rw;
                            r_req_addr <= w_d_addr;
                            r_req_data <= w_d_data;
                            r_req_mask <= w_d_mask;
                        end else begin
                            r_req_rw   <= w_i_rw;
                            r_req_addr <= w_i_addr;
                            r_req_data <= w_i_data;
                            r_req_mask <= w_i_mask;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_req_rw ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    // Responses arriving in any other state are dropped.
                    if (bus.mem_resp_valid) begin
                        r_state <= IDLE;
                        if (r_last_grant == GNT_D) begin
                            r_d_dout       <= bus.mem_resp_data;
                            r_d_resp_valid <= 1'b1;
                        end else begin
                            r_i_dout       <= bus.mem_resp_data;
                            r_i_resp_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.icache_req_ready  = !w_i_valid;
    assign bus.dcache_req_ready  = !w_d_valid;
    assign bus.icache_resp_valid = r_i_resp_valid;
    assign bus.dcache_resp_valid = r_d_resp_valid;
    assign bus.icache_dout       = r_i_dout;
    assign bus.dcache_dout       = r_d_dout;
    assign bus.mem_req_valid     = r_req_valid;
    assign bus.mem_req_rw        = r_req_rw;
    assign bus.mem_req_addr      = r_req_addr;
    assign bus.mem_req_data      = r_req_data;
    assign bus.mem_req_mask      = r_req_mask;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Purpose  : Self-checking bench for core_mem_arbiter: directed scenarios
//            with literal expectations plus a randomized run compared every
//            cycle against a request-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    core_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one pending request per port, one memory
    // transaction at a time. Index 0 = fetch port, 1 = data port.
    // ------------------------------------------------------------------
    logic        m_pend [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_mask [2];
    logic        m_rw   [2];
    bit          m_busy;       // a transaction owns the memory channel
    bit          m_waiting;    // request accepted, read data outstanding
    int          m_port;
    int          m_last;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_mask;
    logic        e_rw;
    logic        e_resp [2];
    logic [31:0] e_dout [2];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
            m_mask[p] = '0;   m_rw[p]   = 1'b0;
            e_resp[p] = 1'b0; e_dout[p] = '0;
        end
        m_busy = 0; m_waiting = 0; m_port = 0; m_last = 0;
        e_addr = '0; e_data = '0; e_mask = '0; e_rw = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs of this cycle.
    task automatic model_step();
        bit cap_i, cap_d;
        int p;
        cap_i = bus.icache_re && !m_pend[0];
        cap_d = (bus.dcache_re || (bus.dcache_we != 4'd0)) && !m_pend[1];
        e_resp[0] = 1'b0;
        e_resp[1] = 1'b0;
        if (!m_busy) begin
            if (m_pend[0] || m_pend[1]) begin
                if (m_pend[0] && m_pend[1]) p = 1 - m_last;
                else                         p = m_pend[1] ? 1 : 0;
                m_last = p; m_port = p; m_busy = 1; m_waiting = 0;
                e_addr = m_addr[p]; e_data = m_data[p];
                e_mask = m_mask[p]; e_rw   = m_rw[p];
            end
        end else if (!m_waiting) begin
            if (bus.mem_req_ready) begin
                if (e_rw) begin
                    m_busy = 0;
                    m_pend[m_port] = 1'b0;
                end else begin
                    m_waiting = 1;
                end
            end
        end else if (bus.mem_resp_valid) begin
            e_dout[m_port] = bus.mem_resp_data;
            e_resp[m_port] = 1'b1;
            m_pend[m_port] = 1'b0;
            m_busy = 0;
        end
        if (cap_i) begin
            m_pend[0] = 1'b1; m_addr[0] = bus.icache_addr;
            m_data[0] = '0;   m_mask[0] = '0; m_rw[0] = 1'b0;
        end
        if (cap_d) begin
            m_pend[1] = 1'b1;         m_addr[1] = bus.dcache_addr;
            m_data[1] = bus.dcache_din; m_mask[1] = bus.dcache_we;
            m_rw[1]   = (bus.dcache_we != 4'd0);
        end
    endtask

    task automatic compare_outputs();
        check("i_req_ready",  32'(bus.icache_req_ready),  32'(!m_pend[0]));
        check("d_req_ready",  32'(bus.dcache_req_ready),  32'(!m_pend[1]));
        check("mem_req_valid", 32'(bus.mem_req_valid),    32'(m_busy && !m_waiting));
        check("mem_req_rw",   32'(bus.mem_req_rw),        32'(e_rw));
        check("mem_req_addr", bus.mem_req_addr,           e_addr);
        check("mem_req_data", bus.mem_req_data,           e_data);
        check("mem_req_mask", 32'(bus.mem_req_mask),      32'(e_mask));
        check("i_resp_valid", 32'(bus.icache_resp_valid), 32'(e_resp[0]));
        check("d_resp_valid", 32'(bus.dcache_resp_valid), 32'(e_resp[1]));
        check("i_dout",       bus.icache_dout,            e_dout[0]);
        check("d_dout",       bus.dcache_dout,            e_dout[1]);
    endtask

    // Compare process: outputs are checked on the falling edge, then the
    // model moves across the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            compare_outputs();
            if (reset) model_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.icache_addr = '0; bus.icache_re = 1'b0;
        bus.dcache_addr = '0; bus.dcache_re = 1'b0;
        bus.dcache_we   = '0; bus.dcache_din = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    int g_cnt;
    logic [1:0] g_seq [4];

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1 reset = 1'b0;
        tick();
        check("rst_i_ready",   32'(bus.icache_req_ready), 32'd1);
        check("rst_d_ready",   32'(bus.dcache_req_ready), 32'd1);
        check("rst_req_valid", 32'(bus.mem_req_valid),    32'd0);
        check("rst_i_dout",    bus.icache_dout,           32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single fetch, one-cycle memory
        bus.icache_re = 1'b1; bus.icache_addr = 32'h100;
        tick();
        clear_inputs();
        check("f_ready_n1", 32'(bus.icache_req_ready), 32'd0);
        tick();
        check("f_valid",    32'(bus.mem_req_valid), 32'd1);
        check("f_addr",     bus.mem_req_addr, 32'h100);
        check("f_rw",       32'(bus.mem_req_rw), 32'd0);
        check("f_ready_n2", 32'(bus.icache_req_ready), 32'd0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("f_valid_drop", 32'(bus.mem_req_valid), 32'd0);
        check("f_ready_n3",   32'(bus.icache_req_ready), 32'd0);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEADBEEF;
        tick();
        clear_inputs();
        check("f_resp",       32'(bus.icache_resp_valid), 32'd1);
        check("f_dout",       bus.icache_dout, 32'hDEADBEEF);
        check("f_ready_resp", 32'(bus.icache_req_ready), 32'd1);
        tick();
        check("f_resp_once",  32'(bus.icache_resp_valid), 32'd0);
        check("f_dout_hold",  bus.icache_dout, 32'hDEADBEEF);

        // Store
        bus.dcache_we = 4'b0011; bus.dcache_din = 32'h12345678; bus.dcache_addr = 32'h200;
        tick();
        clear_inputs();
        check("s_ready_n1", 32'(bus.dcache_req_ready), 32'd0);
        tick();
        check("s_valid", 32'(bus.mem_req_valid), 32'd1);
        check("s_rw",    32'(bus.mem_req_rw), 32'd1);
        check("s_addr",  bus.mem_req_addr, 32'h200);
        check("s_data",  bus.mem_req_data, 32'h12345678);
        check("s_mask",  32'(bus.mem_req_mask), 32'h3);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("s_ready_back", 32'(bus.dcache_req_ready), 32'd1);
        check("s_no_resp",    32'(bus.dcache_resp_valid), 32'd0);
        tick();
        check("s_no_resp2",   32'(bus.dcache_resp_valid), 32'd0);

        // Simultaneous fetch and load after reset: load first
        reset_pulse();
        bus.icache_re = 1'b1; bus.icache_addr = 32'h1100;
        bus.dcache_re = 1'b1; bus.dcache_addr = 32'h2200;
        tick();
        clear_inputs();
        tick();
        check("t_first_addr", bus.mem_req_addr, 32'h2200);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h11111111;
        tick();
        clear_inputs();
        check("t_d_resp",  32'(bus.dcache_resp_valid), 32'd1);
        check("t_d_dout",  bus.dcache_dout, 32'h11111111);
        check("t_i_wait",  32'(bus.icache_req_ready), 32'd0);
        tick();
        check("t_second_valid", 32'(bus.mem_req_valid), 32'd1);
        check("t_second_addr",  bus.mem_req_addr, 32'h1100);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h22222222;
        tick();
        clear_inputs();
        check("t_i_resp", 32'(bus.icache_resp_valid), 32'd1);
        check("t_i_dout", bus.icache_dout, 32'h22222222);

        // Both ports continuously refilled: grants alternate D, I, D, I
        reset_pulse();
        bus.icache_re = 1'b1; bus.icache_addr = 32'h1000;
        bus.dcache_re = 1'b1; bus.dcache_addr = 32'h2000;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5A5A0000;
        g_cnt = 0;
        for (int c = 0; c < 60 && g_cnt < 4; c++) begin
            tick();
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                g_seq[g_cnt] = bus.mem_req_addr[13:12];
                g_cnt++;
            end
        end
        check("alt_count", 32'(g_cnt), 32'd4);
        for (int k = 0; k < 4; k++)
            check("alt_grant", 32'(g_seq[k]), (k % 2 == 0) ? 32'd2 : 32'd1);
        bus.icache_re = 1'b0; bus.dcache_re = 1'b0;
        repeat (12) tick();
        clear_inputs();

        // Memory stalls acceptance for 5 cycles
        reset_pulse();
        bus.dcache_we = 4'b1100; bus.dcache_din = 32'hA5A5A5A5; bus.dcache_addr = 32'h400;
        tick();
        clear_inputs();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(bus.mem_req_valid), 32'd1);
            check("stall_addr",  bus.mem_req_addr, 32'h400);
            check("stall_data",  bus.mem_req_data, 32'hA5A5A5A5);
            check("stall_mask",  32'(bus.mem_req_mask), 32'hC);
            check("stall_rw",    32'(bus.mem_req_rw), 32'd1);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("stall_done", 32'(bus.dcache_req_ready), 32'd1);

        // Reset during WAIT, then a late response
        reset_pulse();
        bus.dcache_re = 1'b1; bus.dcache_addr = 32'h500;
        tick();
        clear_inputs();
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hCAFEF00D;
        tick();
        clear_inputs();
        check("rw_d_resp",  32'(bus.dcache_resp_valid), 32'd0);
        check("rw_d_dout",  bus.dcache_dout, 32'd0);
        check("rw_i_ready", 32'(bus.icache_req_ready), 32'd1);
        check("rw_d_ready", 32'(bus.dcache_req_ready), 32'd1);
        tick();
        check("rw_d_resp2", 32'(bus.dcache_resp_valid), 32'd0);

        // Load and store asserted together: a store
        bus.dcache_re = 1'b1; bus.dcache_we = 4'b1111;
        bus.dcache_din = 32'h0BADF00D; bus.dcache_addr = 32'h600;
        tick();
        clear_inputs();
        tick();
        check("rwe_rw",   32'(bus.mem_req_rw), 32'd1);
        check("rwe_mask", 32'(bus.mem_req_mask), 32'hF);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h12121212;
        check("rwe_ready", 32'(bus.dcache_req_ready), 32'd1);
        tick();
        clear_inputs();
        check("rwe_no_resp", 32'(bus.dcache_resp_valid), 32'd0);
        check("rwe_dout",    bus.dcache_dout, 32'd0);

        // Randomized traffic, including stray responses and resets
        for (int c = 0; c < 4000; c++) begin
            int r;
            reset = ($urandom_range(0, 399) != 0);
            bus.icache_re   = ($urandom_range(0, 1) == 1);
            bus.icache_addr = $urandom;
            r = int'($urandom_range(0, 9));
            bus.dcache_re   = (r < 4) || (r == 9);
            bus.dcache_we   = (r >= 7) ? 4'($urandom_range(1, 15)) : 4'd0;
            bus.dcache_addr = $urandom;
            bus.dcache_din  = $urandom;
            bus.mem_req_ready  = ($urandom_range(0, 1) == 1);
            bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_resp_data  = $urandom;
            tick();
        end
        reset = 1'b1;
        clear_inputs();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
